// File: rtl/seq_palindrome_checker.sv
// seq_palindrome_checker
// Streams in a sequence of symbols, buffers up to MAX_LEN of them, then walks
// mirrored pairs inward one pair per cycle and reports one result beat.
module seq_palindrome_checker #(
  parameter int SYM_W   = 8,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SYM_W-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_is_pal,
  output logic [LEN_W-1:0] out_len,
  output logic             out_overflow
);

  localparam int               IDX_W   = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [SYM_W-1:0] mem [MAX_LEN];
  logic [LEN_W-1:0] count, count_nxt;
  logic             ovf, ovf_nxt;
  logic [LEN_W-1:0] lo, lo_nxt;
  logic [LEN_W-1:0] hi, hi_nxt;
  logic             is_pal_nxt;
  logic [LEN_W-1:0] len_nxt;
  logic             overflow_nxt;
  logic             mem_we;
  logic [LEN_W-1:0] cnt_after;
  logic             ovf_after;

  // Symbol buffer; contents are only meaningful below count, so no reset
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[count[IDX_W-1:0]] <= in_data;
    end
  end

  // Control, pointer and result registers; handshake outputs are decoded from the next state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_LOAD;
      count        <= '0;
      ovf          <= 1'b0;
      lo           <= '0;
      hi           <= '0;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_is_pal   <= 1'b0;
      out_len      <= '0;
      out_overflow <= 1'b0;
    end else begin
      state        <= state_nxt;
      count        <= count_nxt;
      ovf          <= ovf_nxt;
      lo           <= lo_nxt;
      hi           <= hi_nxt;
      in_ready     <= (state_nxt == ST_LOAD);
      out_valid    <= (state_nxt == ST_DONE);
      out_is_pal   <= is_pal_nxt;
      out_len      <= len_nxt;
      out_overflow <= overflow_nxt;
    end
  end

  // Next-state logic: load symbols, compare mirrored pairs with early exit, hold the result
  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    ovf_nxt      = ovf;
    lo_nxt       = lo;
    hi_nxt       = hi;
    is_pal_nxt   = out_is_pal;
    len_nxt      = out_len;
    overflow_nxt = out_overflow;
    mem_we       = 1'b0;
    cnt_after    = count;
    ovf_after    = ovf;

    case (state)
      ST_LOAD: begin
        if (in_valid && in_ready) begin
          if (count < MAX_CNT) begin
            mem_we    = 1'b1;
            cnt_after = count + ONE;
          end else begin
            ovf_after = 1'b1;
          end
          count_nxt = cnt_after;
          ovf_nxt   = ovf_after;
          if (in_last) begin
            if (ovf_after) begin
              state_nxt    = ST_DONE;
              is_pal_nxt   = 1'b0;
              len_nxt      = cnt_after;
              overflow_nxt = 1'b1;
            end else begin
              state_nxt = ST_CHECK;
              lo_nxt    = '0;
              hi_nxt    = cnt_after - ONE;
            end
          end
        end
      end

      ST_CHECK: begin
        if (lo >= hi) begin
          state_nxt    = ST_DONE;
          is_pal_nxt   = 1'b1;
          len_nxt      = count;
          overflow_nxt = 1'b0;
        end else if (mem[lo[IDX_W-1:0]] != mem[hi[IDX_W-1:0]]) begin
          state_nxt    = ST_DONE;
          is_pal_nxt   = 1'b0;
          len_nxt      = count;
          overflow_nxt = 1'b0;
        end else begin
          lo_nxt = lo + ONE;
          hi_nxt = hi - ONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_nxt    = ST_LOAD;
          count_nxt    = '0;
          ovf_nxt      = 1'b0;
          is_pal_nxt   = 1'b0;
          len_nxt      = '0;
          overflow_nxt = 1'b0;
        end
      end

      default: begin
        state_nxt = ST_LOAD;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_palindrome_checker.sv
// Testbench for seq_palindrome_checker: a default-parameter instance with
// directed and random sequences, plus two parameter-sweep instances.
module tb_seq_palindrome_checker;

  typedef logic [31:0] sym_q_t[$];
  typedef struct {
    logic pal;
    int   len;
    logic ovf;
    int   lat;
  } exp_t;

  logic clock;
  logic reset;
  logic sw_reset;
  int   tests_run;
  int   fail_count;
  logic sw1_done;
  logic sw2_done;

  // default instance
  logic       in_valid, in_ready, in_last, out_valid, out_ready, out_is_pal, out_overflow;
  logic [7:0] in_data;
  logic [4:0] out_len;

  // sweep instance 1: SYM_W=1, MAX_LEN=2
  logic       s1_in_valid, s1_in_ready, s1_in_last, s1_out_valid, s1_out_ready, s1_out_is_pal, s1_out_overflow;
  logic [0:0] s1_in_data;
  logic [1:0] s1_out_len;

  // sweep instance 2: SYM_W=32, MAX_LEN=64
  logic        s2_in_valid, s2_in_ready, s2_in_last, s2_out_valid, s2_out_ready, s2_out_is_pal, s2_out_overflow;
  logic [31:0] s2_in_data;
  logic [6:0]  s2_out_len;

  exp_t sb[$];
  exp_t sb1[$];
  exp_t sb2[$];

  seq_palindrome_checker dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_is_pal(out_is_pal),
    .out_len(out_len), .out_overflow(out_overflow)
  );

  seq_palindrome_checker #(.SYM_W(1), .MAX_LEN(2)) dut_sw1 (
    .clock(clock), .reset(sw_reset),
    .in_valid(s1_in_valid), .in_ready(s1_in_ready), .in_data(s1_in_data), .in_last(s1_in_last),
    .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_is_pal(s1_out_is_pal),
    .out_len(s1_out_len), .out_overflow(s1_out_overflow)
  );

  seq_palindrome_checker #(.SYM_W(32), .MAX_LEN(64)) dut_sw2 (
    .clock(clock), .reset(sw_reset),
    .in_valid(s2_in_valid), .in_ready(s2_in_ready), .in_data(s2_in_data), .in_last(s2_in_last),
    .out_valid(s2_out_valid), .out_ready(s2_out_ready), .out_is_pal(s2_out_is_pal),
    .out_len(s2_out_len), .out_overflow(s2_out_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: latency counts edges after the last-beat edge until out_valid is seen
  function automatic exp_t model(input sym_q_t q, input int max_len);
    exp_t e;
    int   n;
    n     = q.size();
    e.ovf = (n > max_len);
    e.len = e.ovf ? max_len : n;
    e.pal = 1'b1;
    e.lat = 1 + n / 2;
    if (e.ovf) begin
      e.pal = 1'b0;
      e.lat = 0;
    end else begin
      for (int i = 0; i < n / 2; i++) begin
        if (q[i] != q[n-1-i]) begin
          e.pal = 1'b0;
          e.lat = 1 + i;
          break;
        end
      end
    end
    return e;
  endfunction

  function automatic sym_q_t gen_seq(input int len, input bit make_pal, input logic [31:0] alpha);
    sym_q_t q;
    for (int i = 0; i < len; i++) q.push_back($urandom_range(0, alpha));
    if (make_pal) begin
      for (int i = 0; i < len / 2; i++) q[len-1-i] = q[i];
    end
    return q;
  endfunction

  function automatic sym_q_t fill_seq(input int len, input logic [31:0] val);
    sym_q_t q;
    for (int i = 0; i < len; i++) q.push_back(val);
    return q;
  endfunction

  // Drive one sequence into the default instance and check its result beat.
  // Starts and ends 1 time unit after a rising edge.
  task automatic apply_stimulus(input sym_q_t q, input bit gaps, input int hold, input int abort_at);
    exp_t e;
    logic rdy;
    int   w, n, total, g;
    logic seen;
    sb.push_back(model(q, 16));
    total = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        in_valid = 1'b0;
        repeat (g) begin @(posedge clock); #1; end
      end
      in_valid = 1'b1;
      in_data  = q[i][7:0];
      in_last  = (i == q.size() - 1);
      w = 0;
      do begin
        @(negedge clock); rdy = in_ready;
        @(posedge clock); #1;
        w++;
      end while (!rdy && w < 50);
      if (!rdy) check_output("accept_timeout", rdy, 1);
      total += w;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!gaps) check_output("load_cycles", total, q.size());

    if (abort_at > 0) begin
      repeat (abort_at) @(posedge clock);
      #2 reset = 1'b1;
      #1;
      check_output("abort_in_ready", in_ready, 0);
      check_output("abort_out_valid", out_valid, 0);
      check_output("abort_out_len", out_len, 0);
      check_output("abort_is_pal", out_is_pal, 0);
      e = sb.pop_front();
      @(posedge clock);
      #3 reset = 1'b0;
      seen = 1'b0;
      repeat (12) begin
        @(negedge clock);
        if (out_valid) seen = 1'b1;
      end
      check_output("abort_no_result", seen, 0);
      @(posedge clock); #1;
      check_output("abort_in_ready_after", in_ready, 1);
    end else begin
      n = 0;
      @(negedge clock);
      while (!out_valid && n < 100) begin
        @(posedge clock); n++;
        @(negedge clock);
      end
      e = sb.pop_front();
      check_output("latency", n, e.lat);
      check_output("out_valid", out_valid, 1);
      check_output("out_is_pal", out_is_pal, e.pal);
      check_output("out_len", out_len, e.len);
      check_output("out_overflow", out_overflow, e.ovf);
      check_output("done_in_ready", in_ready, 0);
      repeat (hold) begin
        @(posedge clock);
        @(negedge clock);
        check_output("hold_valid", out_valid, 1);
        check_output("hold_is_pal", out_is_pal, e.pal);
        check_output("hold_len", out_len, e.len);
        check_output("hold_overflow", out_overflow, e.ovf);
        check_output("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      check_output("post_hs_in_ready", in_ready, 1);
      check_output("post_hs_out_valid", out_valid, 0);
    end
  endtask

  task automatic sweep1_stimulus(input sym_q_t q);
    exp_t e;
    logic rdy;
    int   w;
    sb1.push_back(model(q, 2));
    for (int i = 0; i < q.size(); i++) begin
      s1_in_valid = 1'b1;
      s1_in_data  = q[i][0];
      s1_in_last  = (i == q.size() - 1);
      w = 0;
      do begin
        @(negedge clock); rdy = s1_in_ready;
        @(posedge clock); #1;
        w++;
      end while (!rdy && w < 50);
      if (!rdy) check_output("sw1_accept_timeout", rdy, 1);
    end
    s1_in_valid = 1'b0;
    s1_in_last  = 1'b0;
    w = 0;
    @(negedge clock);
    while (!s1_out_valid && w < 200) begin @(negedge clock); w++; end
    e = sb1.pop_front();
    check_output("sw1_out_valid", s1_out_valid, 1);
    check_output("sw1_is_pal", s1_out_is_pal, e.pal);
    check_output("sw1_len", s1_out_len, e.len);
    check_output("sw1_overflow", s1_out_overflow, e.ovf);
    s1_out_ready = 1'b1;
    @(posedge clock); #1;
    s1_out_ready = 1'b0;
  endtask

  task automatic sweep2_stimulus(input sym_q_t q);
    exp_t e;
    logic rdy;
    int   w;
    sb2.push_back(model(q, 64));
    for (int i = 0; i < q.size(); i++) begin
      s2_in_valid = 1'b1;
      s2_in_data  = q[i];
      s2_in_last  = (i == q.size() - 1);
      w = 0;
      do begin
        @(negedge clock); rdy = s2_in_ready;
        @(posedge clock); #1;
        w++;
      end while (!rdy && w < 50);
      if (!rdy) check_output("sw2_accept_timeout", rdy, 1);
    end
    s2_in_valid = 1'b0;
    s2_in_last  = 1'b0;
    w = 0;
    @(negedge clock);
    while (!s2_out_valid && w < 200) begin @(negedge clock); w++; end
    e = sb2.pop_front();
    check_output("sw2_out_valid", s2_out_valid, 1);
    check_output("sw2_is_pal", s2_out_is_pal, e.pal);
    check_output("sw2_len", s2_out_len, e.len);
    check_output("sw2_overflow", s2_out_overflow, e.ovf);
    s2_out_ready = 1'b1;
    @(posedge clock); #1;
    s2_out_ready = 1'b0;
  endtask

  // Sweep instance 1: random short binary sequences including overflow
  initial begin
    sw1_done = 1'b0;
    s1_in_valid = 1'b0; s1_in_data = '0; s1_in_last = 1'b0; s1_out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    for (int t = 0; t < 40; t++) begin
      sweep1_stimulus(gen_seq($urandom_range(1, 4), bit'($urandom_range(0, 1)), 32'd1));
    end
    sw1_done = 1'b1;
  end

  // Sweep instance 2: random wide sequences up to and beyond 64 symbols
  initial begin
    sw2_done = 1'b0;
    s2_in_valid = 1'b0; s2_in_data = '0; s2_in_last = 1'b0; s2_out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    for (int t = 0; t < 30; t++) begin
      sweep2_stimulus(gen_seq($urandom_range(1, 66), bit'($urandom_range(0, 1)), 32'hFFFF_FFFF));
    end
    sweep2_stimulus(fill_seq(64, 32'hDEAD_BEEF));
    sweep2_stimulus(fill_seq(65, 32'h1234_5678));
    sw2_done = 1'b1;
  end

  // Main sequence: reset behaviour, directed cases, backpressure, abort, random
  initial begin
    sym_q_t q;
    sym_q_t q2;
    tests_run  = 0;
    fail_count = 0;
    reset      = 1'b1;
    sw_reset   = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_last    = 1'b0;
    out_ready  = 1'b0;

    #3;
    check_output("rst_in_ready", in_ready, 0);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_is_pal", out_is_pal, 0);
    check_output("rst_len", out_len, 0);
    check_output("rst_overflow", out_overflow, 0);
    #4;
    reset    = 1'b0;
    sw_reset = 1'b0;
    #1;
    check_output("pre_edge_in_ready", in_ready, 0);
    @(posedge clock); #1;
    check_output("release_in_ready", in_ready, 1);

    q = '{32'h11, 32'h22, 32'h33, 32'h22, 32'h11};
    apply_stimulus(q, 0, 0, 0);
    q = '{32'hA0, 32'hB0, 32'hB1, 32'hA0};
    apply_stimulus(q, 0, 0, 0);
    q = '{32'h5A};
    apply_stimulus(q, 0, 0, 0);
    apply_stimulus(fill_seq(17, 32'h00), 0, 0, 0);
    apply_stimulus(fill_seq(16, 32'h00), 0, 0, 0);

    q = '{32'h11, 32'h22, 32'h33, 32'h22, 32'h11};
    apply_stimulus(q, 1, 0, 0);
    q = '{32'hA0, 32'hB0, 32'hB1, 32'hA0};
    apply_stimulus(q, 1, 0, 0);

    q  = '{32'h01, 32'h02, 32'h01};
    q2 = '{32'h07, 32'h08, 32'h09, 32'h07};
    apply_stimulus(q, 0, 5, 0);
    apply_stimulus(q2, 0, 0, 0);

    apply_stimulus(fill_seq(16, 32'h00), 0, 0, 3);
    q = '{32'h3C, 32'h3C};
    apply_stimulus(q, 0, 0, 0);

    for (int t = 0; t < 20; t++) begin
      apply_stimulus(gen_seq($urandom_range(1, 18), bit'($urandom_range(0, 1)), 32'd3),
                     bit'($urandom_range(0, 1)), $urandom_range(0, 2), 0);
    end

    for (int i = 0; i < 20000 && !(sw1_done && sw2_done); i++) @(posedge clock);
    if (!(sw1_done && sw2_done)) check_output("sweep_timeout", {sw1_done, sw2_done}, 2'b11);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
